// File: rtl/spi_word_bus_bridge.sv
// Bridges SPI command words to single register-bus accesses; each frame's MISO
// word carries the response of the previous frame's access.
module spi_word_bus_bridge #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 24,
    parameter int TIMEOUT    = 255,
    localparam int WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                  system_clk,
    input  logic                  system_rst_n,
    input  logic [WIDTH-1:0]      spi_value_mosi,
    input  logic                  spi_value_valid,
    input  logic                  spi_cs_stop,
    output logic [WIDTH-1:0]      spi_value_miso,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack,
    output logic                  busy,
    output logic                  overrun
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0]      miso_q, miso_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  overrun_q, overrun_d;

    // Bus handshake: bus_req rises with we/addr/wdata stable and stays high
    // until the cycle after bus_ack is sampled high (or the timeout aborts);
    // bus_ack is ignored whenever bus_req is low.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        miso_d    = miso_q;
        cnt_d     = cnt_q;
        overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (spi_cs_stop) begin
                    if (spi_value_valid) begin
                        we_d    = spi_value_mosi[WIDTH-1];
                        addr_d  = spi_value_mosi[WIDTH-2:DATA_WIDTH];
                        wdata_d = spi_value_mosi[DATA_WIDTH-1:0];
                        cnt_d   = '0;
                        state_d = REQ;
                    end else begin
                        miso_d = '0;
                    end
                end
            end
            REQ: begin
                overrun_d = spi_cs_stop;
                cnt_d     = cnt_q + CNT_W'(1);
                // Ack has priority over a timeout landing in the same cycle.
                if (bus_ack) begin
                    miso_d  = {1'b1, addr_q, (we_q ? wdata_q : bus_rdata)};
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    miso_d  = {1'b0, addr_q, {DATA_WIDTH{1'b0}}};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (!system_rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            miso_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            miso_q    <= miso_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus_req        = (state_q == REQ);
    assign busy           = (state_q == REQ);
    assign bus_we         = we_q;
    assign bus_addr       = addr_q;
    assign bus_wdata      = wdata_q;
    assign spi_value_miso = miso_q;
    assign overrun        = overrun_q;

endmodule
